// File: rtl/ahb_arb_pkg.sv
// Shared constants, request record and arbitration helper for the
// two-master AHB-Lite data-side arbiter.
package ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int ARB_ROUND_ROBIN = 0;
    localparam int ARB_FIXED       = 1;

    localparam int REQ_ADDR_W = 32;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic                  write;
        logic [2:0]            size;
    } ahb_req_t;

    // Under contention the master that did not win last time goes next,
    // unless fixed priority hands every tie to master 0.
    function automatic logic pick_winner(input logic req0, input logic req1,
                                         input logic last_grant, input logic fixed_prio);
        logic win;
        if (req0 && req1) begin
            win = fixed_prio ? M0 : ~last_grant;
        end else if (req1) begin
            win = M1;
        end else begin
            win = M0;
        end
        return win;
    endfunction

endpackage

// File: rtl/ahb_req_buffer.sv
// One-entry holding register for an address phase that was accepted from a
// master but could not be issued to the slave in the same cycle.
module ahb_req_buffer
    import ahb_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic              issue,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              write_in,
    input  logic [2:0]        size_in,
    output logic              pend,
    output logic [ADDR_W-1:0] addr,
    output logic              write,
    output logic [2:0]        size
);

    // capture and issue never coincide: capture needs an empty entry and
    // issue needs a full one.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend  <= 1'b0;
            addr  <= '0;
            write <= 1'b0;
            size  <= 3'b000;
        end else if (capture) begin
            pend  <= 1'b1;
            addr  <= addr_in;
            write <= write_in;
            size  <= size_in;
        end else if (issue) begin
            pend  <= 1'b0;
        end
    end

endmodule

// File: rtl/ahb_data_arbiter.sv
// Two-master AHB-Lite arbiter sharing the data-side slave: live pass-through,
// per-master one-entry buffering and data-phase ownership tracking.
module ahb_data_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic [ADDR_W-1:0] HADDR_M0,
    input  logic [ADDR_W-1:0] HADDR_M1,
    input  logic [1:0]        HTRANS_M0,
    input  logic [1:0]        HTRANS_M1,
    input  logic              HWRITE_M0,
    input  logic              HWRITE_M1,
    input  logic [2:0]        HSIZE_M0,
    input  logic [2:0]        HSIZE_M1,
    input  logic [DATA_W-1:0] HWDATA_M0,
    input  logic [DATA_W-1:0] HWDATA_M1,
    output logic [DATA_W-1:0] HRDATA_M0,
    output logic [DATA_W-1:0] HRDATA_M1,
    output logic              HREADY_M0,
    output logic              HREADY_M1,
    output logic              HRESP_M0,
    output logic              HRESP_M1,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADYOUT,
    input  logic              HRESP,
    output logic              HMASTER
);

    logic              pend0, pend1;
    logic [ADDR_W-1:0] buf_addr0, buf_addr1;
    logic              buf_write0, buf_write1;
    logic [2:0]        buf_size0, buf_size1;

    logic              dph_valid;
    logic              dph_owner;
    logic              last_grant;
    logic [ADDR_W-1:0] held_addr;
    logic              held_write;
    logic [2:0]        held_size;

    logic              ready0, ready1;
    logic              live0, live1;
    logic              req0, req1;
    logic              grant, winner;
    logic              capture0, capture1, issue0, issue1;
    logic [ADDR_W-1:0] src_addr0, src_addr1, win_addr;
    logic              src_write0, src_write1, win_write;
    logic [2:0]        src_size0, src_size1, win_size;

    // Only HTRANS[1] distinguishes IDLE from NONSEQ for these masters.
    logic unused_trans_bits;
    assign unused_trans_bits = HTRANS_M0[0] ^ HTRANS_M1[0];

    // A master is stalled while it has a buffered entry, and otherwise
    // follows the slave only while it owns the data phase.
    always_comb begin
        ready0 = 1'b1;
        ready1 = 1'b1;
        if (!HRESET) begin
            if (pend0) begin
                ready0 = 1'b0;
            end else if (dph_valid && dph_owner == M0) begin
                ready0 = HREADYOUT;
            end
            if (pend1) begin
                ready1 = 1'b0;
            end else if (dph_valid && dph_owner == M1) begin
                ready1 = HREADYOUT;
            end
        end
    end

    assign live0 = HTRANS_M0[1] & ready0 & ~pend0;
    assign live1 = HTRANS_M1[1] & ready1 & ~pend1;
    assign req0  = pend0 | live0;
    assign req1  = pend1 | live1;

    assign src_addr0  = pend0 ? buf_addr0  : HADDR_M0;
    assign src_write0 = pend0 ? buf_write0 : HWRITE_M0;
    assign src_size0  = pend0 ? buf_size0  : HSIZE_M0;
    assign src_addr1  = pend1 ? buf_addr1  : HADDR_M1;
    assign src_write1 = pend1 ? buf_write1 : HWRITE_M1;
    assign src_size1  = pend1 ? buf_size1  : HSIZE_M1;

    assign grant  = HREADYOUT & (req0 | req1) & ~HRESET;
    assign winner = pick_winner(req0, req1, last_grant, FIXED_PRIO == ARB_FIXED);

    assign win_addr  = (winner == M1) ? src_addr1  : src_addr0;
    assign win_write = (winner == M1) ? src_write1 : src_write0;
    assign win_size  = (winner == M1) ? src_size1  : src_size0;

    assign capture0 = live0 & ~(grant & (winner == M0));
    assign capture1 = live1 & ~(grant & (winner == M1));
    assign issue0   = pend0 & grant & (winner == M0);
    assign issue1   = pend1 & grant & (winner == M1);

    ahb_req_buffer #(.ADDR_W(ADDR_W)) u_buf0 (
        .clk      (HCLK),
        .reset    (HRESET),
        .capture  (capture0),
        .issue    (issue0),
        .addr_in  (HADDR_M0),
        .write_in (HWRITE_M0),
        .size_in  (HSIZE_M0),
        .pend     (pend0),
        .addr     (buf_addr0),
        .write    (buf_write0),
        .size     (buf_size0)
    );

    ahb_req_buffer #(.ADDR_W(ADDR_W)) u_buf1 (
        .clk      (HCLK),
        .reset    (HRESET),
        .capture  (capture1),
        .issue    (issue1),
        .addr_in  (HADDR_M1),
        .write_in (HWRITE_M1),
        .size_in  (HSIZE_M1),
        .pend     (pend1),
        .addr     (buf_addr1),
        .write    (buf_write1),
        .size     (buf_size1)
    );

    // last_grant starts at M1 so master 0 takes the first tie after reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            last_grant <= M1;
            dph_valid  <= 1'b0;
            dph_owner  <= M0;
            held_addr  <= '0;
            held_write <= 1'b0;
            held_size  <= 3'b000;
        end else begin
            if (grant) begin
                last_grant <= winner;
                held_addr  <= win_addr;
                held_write <= win_write;
                held_size  <= win_size;
            end
            if (HREADYOUT) begin
                dph_valid <= grant;
                if (grant) begin
                    dph_owner <= winner;
                end
            end
        end
    end

    assign HTRANS = grant ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR  = grant ? win_addr  : held_addr;
    assign HWRITE = grant ? win_write : held_write;
    assign HSIZE  = grant ? win_size  : held_size;

    assign HWDATA    = (dph_owner == M1) ? HWDATA_M1 : HWDATA_M0;
    assign HRDATA_M0 = HRDATA;
    assign HRDATA_M1 = HRDATA;
    assign HREADY_M0 = ready0;
    assign HREADY_M1 = ready1;
    assign HRESP_M0  = ~HRESET & dph_valid & (dph_owner == M0) & HRESP;
    assign HRESP_M1  = ~HRESET & dph_valid & (dph_owner == M1) & HRESP;
    assign HMASTER   = HRESET ? M0 : dph_owner;

endmodule
